// File: rtl/heap_topk_sorter.sv
// Top-K record sorter: keeps the DEPTH best-scoring records of a frame in a
// descending register list and drains them best-first when the frame is flushed.
module heap_topk_sorter #(
   parameter int WIDTH     = 344,
   parameter int DEPTH     = 10,
   parameter int SCORE_LSB = 0,
   parameter int SCORE_W   = 16,
   localparam int CW       = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] dIn,
   input  logic             valid,
   input  logic             flush,
   output logic [WIDTH-1:0] dOut,
   output logic             dValid,
   output logic             done,
   output logic             busy,
   output logic [CW-1:0]    count,
   output logic [15:0]      dropCnt
);

   typedef enum logic {IDLE, DRAIN} stateT;

   stateT               state;
   logic [WIDTH-1:0]    list     [DEPTH];
   logic [WIDTH-1:0]    nextList [DEPTH];
   logic [DEPTH-1:0]    ge;
   logic [SCORE_W-1:0]  inScore;
   logic                doInsert;
   logic [CW-1:0]       insCount;
   logic [CW-1:0]       rdIdx;

   // Parallel compare-shift: ge is a prefix of ones over the valid entries, so the
   // first cleared position receives dIn and everything after slides down one slot.
   always_comb begin
      inScore  = dIn[SCORE_LSB +: SCORE_W];
      ge       = '0;
      for (int i = 0; i < DEPTH; i++) begin
         ge[i] = (CW'(i) < count) && (list[i][SCORE_LSB +: SCORE_W] >= inScore);
      end
      for (int i = 0; i < DEPTH; i++) begin
         nextList[i] = list[i];
         if (!ge[i]) begin
            if (i == 0) begin
               nextList[i] = dIn;
            end else if (ge[i-1]) begin
               nextList[i] = dIn;
            end else begin
               nextList[i] = list[i-1];
            end
         end
      end
      doInsert = valid && ((count < CW'(DEPTH)) ||
                           (inScore > list[DEPTH-1][SCORE_LSB +: SCORE_W]));
      insCount = (count < CW'(DEPTH)) ? CW'(count + 1'b1) : count;
   end

   // Single FSM: ingest in IDLE, emit entry[rdIdx] each DRAIN cycle, then clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         count   <= '0;
         rdIdx   <= '0;
         dOut    <= '0;
         dValid  <= 1'b0;
         done    <= 1'b0;
         busy    <= 1'b0;
         dropCnt <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            list[i] <= '0;
         end
      end else begin
         case (state)
            IDLE: begin
               dValid <= 1'b0;
               done   <= 1'b0;
               if (doInsert) begin
                  list  <= nextList;
                  count <= insCount;
               end
               if (flush) begin
                  state <= DRAIN;
                  busy  <= 1'b1;
                  rdIdx <= '0;
                  done  <= (count == '0) && !doInsert;
               end
            end
            DRAIN: begin
               if (valid && (dropCnt != 16'hFFFF)) begin
                  dropCnt <= dropCnt + 16'd1;
               end
               if (rdIdx < count) begin
                  dOut   <= list[rdIdx];
                  dValid <= 1'b1;
                  done   <= (rdIdx == CW'(count - 1'b1));
                  rdIdx  <= CW'(rdIdx + 1'b1);
               end else begin
                  state  <= IDLE;
                  busy   <= 1'b0;
                  dValid <= 1'b0;
                  done   <= 1'b0;
                  count  <= '0;
                  rdIdx  <= '0;
                  for (int i = 0; i < DEPTH; i++) begin
                     list[i] <= '0;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
